// File: rtl/linked_list_rd_ctrl_pkg.sv
// linked_list_pkg: shared widths, node layout and read-FSM state encoding for the linked-list controllers.
package linked_list_pkg;
  localparam int WR_ADDR_WD  = 8;
  localparam int PAYLOAD_WD  = 24;
  localparam int WR_DATA_WD  = WR_ADDR_WD + PAYLOAD_WD;
  localparam int DATA_DEPTH  = 1 << WR_ADDR_WD;
  localparam int MAX_LEN_WD  = 9;
  localparam int TIMEOUT_CYC = 16;
  localparam logic [WR_ADDR_WD-1:0] NULL_PTR = '1;
  typedef struct packed {
    logic [WR_ADDR_WD-1:0] next_ptr;
    logic [PAYLOAD_WD-1:0] payload;
  } ll_node_t;
  typedef enum logic [2:0] {IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, OUT = 3'd3, DONE = 3'd4} ll_rd_state_e;
endpackage

// File: rtl/linked_list_rd_ctrl_if.sv
// linked_list_rd_ctrl_if: traversal request, memory read port, payload stream and status of the read controller.
interface linked_list_rd_ctrl_if;
  import linked_list_pkg::*;
  logic                  trav_start;
  logic [WR_ADDR_WD-1:0] trav_head;
  logic [MAX_LEN_WD-1:0] trav_max_len;
  logic                  rd_vld;
  logic [WR_ADDR_WD-1:0] rd_addr;
  logic [WR_DATA_WD-1:0] rd_data;
  logic                  rd_data_out_vld;
  logic                  out_vld;
  logic                  out_ready;
  logic [PAYLOAD_WD-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [MAX_LEN_WD-1:0] node_cnt;
  modport master (
    input  trav_start, trav_head, trav_max_len, rd_data, rd_data_out_vld, out_ready,
    output rd_vld, rd_addr, out_vld, out_data, out_last, busy, done, err, node_cnt
  );
  modport slave (
    output trav_start, trav_head, trav_max_len, rd_data, rd_data_out_vld, out_ready,
    input  rd_vld, rd_addr, out_vld, out_data, out_last, busy, done, err, node_cnt
  );
endinterface

// File: rtl/linked_list_rd_out_stage.sv
// linked_list_rd_out_stage: single-entry payload register, held stable while valid until the consumer takes it.
module linked_list_rd_out_stage
  import linked_list_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [PAYLOAD_WD-1:0] load_data,
  input  logic                  load_last,
  input  logic                  ready,
  output logic                  vld,
  output logic [PAYLOAD_WD-1:0] data,
  output logic                  last,
  output logic                  fire
);
  assign fire = vld & ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld  <= 1'b0;
      data <= '0;
      last <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= load_data;
      last <= load_last;
    end else if (fire) begin
      vld  <= 1'b0;
      last <= 1'b0;
    end
  end
endmodule

// File: rtl/linked_list_rd_ctrl.sv
// linked_list_rd_ctrl: walks a linked list from a head pointer and streams each node payload, flagging the last.
// Optional LL_RD_TIMEOUT_EN adds a watchdog that aborts with err when a memory response never arrives.
module linked_list_rd_ctrl
  import linked_list_pkg::*;
(
  input logic clk,
  input logic reset_n,
  linked_list_rd_ctrl_if.master bus
);
  ll_rd_state_e          state;
  logic [WR_ADDR_WD-1:0] cur_ptr;
  logic [MAX_LEN_WD-1:0] limit;
  logic [MAX_LEN_WD-1:0] cnt;
  logic                  err_pend;
  ll_node_t              node;
  logic                  at_lim;
  logic                  fire;
  logic                  tmo;
  assign node   = ll_node_t'(bus.rd_data);
  assign at_lim = (cnt + MAX_LEN_WD'(1)) == limit;
`ifdef LL_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tmo_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_cnt <= '0;
    else          tmo_cnt <= (state == WAIT) ? tmo_cnt + TW'(1) : '0;
  end
  assign tmo = (state == WAIT) && !bus.rd_data_out_vld && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cur_ptr  <= '0;
      limit    <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.trav_start) begin
          cnt      <= '0;
          err_pend <= 1'b0;
          cur_ptr  <= bus.trav_head;
          limit    <= (bus.trav_max_len == '0) ? '1 : bus.trav_max_len;
          state    <= (bus.trav_head == NULL_PTR) ? DONE : ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (bus.rd_data_out_vld) begin
          cur_ptr  <= node.next_ptr;
          err_pend <= (node.next_ptr != NULL_PTR) && at_lim;
          state    <= OUT;
        end else if (tmo) begin
          err_pend <= 1'b1;
          state    <= DONE;
        end
        OUT: if (fire) begin
          cnt   <= cnt + MAX_LEN_WD'(1);
          state <= bus.out_last ? DONE : ISSUE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.rd_vld   = state == ISSUE;
  assign bus.rd_addr  = cur_ptr;
  assign bus.busy     = state != IDLE;
  assign bus.done     = state == DONE;
  assign bus.err      = (state == DONE) && err_pend;
  assign bus.node_cnt = cnt;
  // the limit check rides with the capture so the node at the limit is emitted as last
  linked_list_rd_out_stage u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      ((state == WAIT) && bus.rd_data_out_vld),
    .load_data (node.payload),
    .load_last ((node.next_ptr == NULL_PTR) || at_lim),
    .ready     (bus.out_ready),
    .vld       (bus.out_vld),
    .data      (bus.out_data),
    .last      (bus.out_last),
    .fire      (fire)
  );
endmodule

// File: tb/tb_linked_list_rd_ctrl.sv
// tb_linked_list_rd_ctrl: table of traversal scenarios against a 1-cycle-latency memory model, plus reset/timeout sequences.
module tb_linked_list_rd_ctrl;
  import linked_list_pkg::*;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;
  linked_list_rd_ctrl_if bus();
  linked_list_rd_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  logic [WR_DATA_WD-1:0] mem [DATA_DEPTH];
  bit suppress;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_data_out_vld <= 1'b0;
      bus.rd_data         <= '0;
    end else begin
      bus.rd_data_out_vld <= bus.rd_vld && !suppress;
      bus.rd_data         <= bus.rd_vld ? mem[bus.rd_addr] : 32'hDEAD_BEEF;
    end
  end
  typedef struct {
    logic [7:0]       head;
    logic [8:0]       max_len;
    int               stall_node;
    int               stall_cyc;
    int               inject;
    int               n;
    logic [3:0][7:0]  addr;
    logic [3:0][23:0] pay;
    logic             err;
  } vec_t;
  vec_t vecs[8];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic start(input logic [7:0] h, input logic [8:0] m);
    @(negedge clk);
    bus.trav_head    = h;
    bus.trav_max_len = m;
    bus.trav_start   = 1'b1;
    @(negedge clk);
    bus.trav_start   = 1'b0;
  endtask
  task automatic run(input vec_t v, input int id);
    int na, no, stall, cdone;
    bit got;
    na = 0; no = 0; stall = v.stall_cyc; got = 0; cdone = -1;
    bus.out_ready = 1'b1;
    start(v.head, v.max_len);
    for (int c = 0; c < 200 && !got; c++) begin
      if (c == v.inject) begin
        bus.trav_start   = 1'b1;
        bus.trav_head    = 8'd3;
        bus.trav_max_len = 9'd1;
      end else bus.trav_start = 1'b0;
      if (bus.rd_vld) begin
        if (na < 4) chk($sformatf("v%0d addr%0d", id, na), {24'd0, bus.rd_addr}, {24'd0, v.addr[na]});
        na++;
      end
      if (bus.out_vld) begin
        if (no == v.stall_node && stall > 0) begin
          chk($sformatf("v%0d stall data", id), {8'd0, bus.out_data}, {8'd0, v.pay[no]});
          chk($sformatf("v%0d stall rd_vld", id), {31'd0, bus.rd_vld}, 32'd0);
          bus.out_ready = 1'b0;
          stall--;
        end else begin
          bus.out_ready = 1'b1;
          if (no < 4) begin
            chk($sformatf("v%0d data%0d", id, no), {8'd0, bus.out_data}, {8'd0, v.pay[no]});
            chk($sformatf("v%0d last%0d", id, no), {31'd0, bus.out_last}, (no == v.n - 1) ? 32'd1 : 32'd0);
          end
          no++;
        end
      end else bus.out_ready = 1'b1;
      if (bus.done) begin
        got = 1;
        cdone = c;
        chk($sformatf("v%0d err", id), {31'd0, bus.err}, {31'd0, v.err});
        chk($sformatf("v%0d node_cnt", id), {23'd0, bus.node_cnt}, v.n);
      end
      @(negedge clk);
    end
    bus.trav_start = 1'b0;
    chk($sformatf("v%0d done seen", id), {31'd0, got}, 32'd1);
    chk($sformatf("v%0d done cycle", id), cdone, 3 * v.n + v.stall_cyc);
    chk($sformatf("v%0d reads", id), na, v.n);
    chk($sformatf("v%0d outputs", id), no, v.n);
    chk($sformatf("v%0d busy after done", id), {31'd0, bus.busy}, 32'd0);
    chk($sformatf("v%0d done width", id), {31'd0, bus.done}, 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    bit seen;
    for (int i = 0; i < DATA_DEPTH; i++) mem[i] = '0;
    mem[5] = {8'd9,   24'h00000A};
    mem[9] = {8'd2,   24'h00000B};
    mem[2] = {8'hFF,  24'h00000C};
    mem[3] = {8'd3,   24'h000033};
    vecs[0] = '{8'h05, 9'd0, -1, 0, -1, 3, {8'd0, 8'd2, 8'd9, 8'd5}, {24'h0, 24'hC, 24'hB, 24'hA}, 1'b0};
    vecs[1] = '{8'hFF, 9'd0, -1, 0, -1, 0, {8'd0, 8'd0, 8'd0, 8'd0}, {24'h0, 24'h0, 24'h0, 24'h0}, 1'b0};
    vecs[2] = '{8'h03, 9'd4, -1, 0, -1, 4, {8'd3, 8'd3, 8'd3, 8'd3}, {24'h33, 24'h33, 24'h33, 24'h33}, 1'b1};
    vecs[3] = '{8'h05, 9'd0, 1, 5, -1, 3, {8'd0, 8'd2, 8'd9, 8'd5}, {24'h0, 24'hC, 24'hB, 24'hA}, 1'b0};
    vecs[4] = '{8'h05, 9'd2, -1, 0, -1, 2, {8'd0, 8'd0, 8'd9, 8'd5}, {24'h0, 24'h0, 24'hB, 24'hA}, 1'b1};
    vecs[5] = '{8'h02, 9'd1, -1, 0, -1, 1, {8'd0, 8'd0, 8'd0, 8'd2}, {24'h0, 24'h0, 24'h0, 24'hC}, 1'b0};
    vecs[6] = '{8'h05, 9'd0, -1, 0, 2, 3, {8'd0, 8'd2, 8'd9, 8'd5}, {24'h0, 24'hC, 24'hB, 24'hA}, 1'b0};
    vecs[7] = '{8'h05, 9'd3, -1, 0, -1, 3, {8'd0, 8'd2, 8'd9, 8'd5}, {24'h0, 24'hC, 24'hB, 24'hA}, 1'b0};
    suppress = 0;
    bus.trav_start = 1'b0;
    bus.trav_head = '0;
    bus.trav_max_len = '0;
    bus.out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset err", {31'd0, bus.err}, 32'd0);
    chk("reset rd_vld", {31'd0, bus.rd_vld}, 32'd0);
    chk("reset rd_addr", {24'd0, bus.rd_addr}, 32'd0);
    chk("reset out_vld", {31'd0, bus.out_vld}, 32'd0);
    chk("reset out_data", {8'd0, bus.out_data}, 32'd0);
    chk("reset node_cnt", {23'd0, bus.node_cnt}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) run(vecs[i], i);
    suppress = 1;
`ifdef LL_RD_TIMEOUT_EN
    start(8'h05, 9'd0);
    chk("tmo issue", {31'd0, bus.rd_vld}, 32'd1);
    @(negedge clk);
    k = 0;
    seen = 0;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.out_vld) seen = 1;
    end
    chk("tmo cycles", k, TIMEOUT_CYC);
    chk("tmo err", {31'd0, bus.err}, 32'd1);
    chk("tmo no out_vld", {31'd0, seen}, 32'd0);
    @(negedge clk);
`else
    start(8'h05, 9'd0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("hang busy", {31'd0, bus.busy}, 32'd1);
    chk("hang no done", {31'd0, seen}, 32'd0);
`endif
    start(8'h05, 9'd0);
    @(negedge clk);
    chk("wait busy", {31'd0, bus.busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst rd_vld", {31'd0, bus.rd_vld}, 32'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("rst no done", {31'd0, seen}, 32'd0);
    reset_n = 1'b1;
    suppress = 0;
    chk("rst node_cnt", {23'd0, bus.node_cnt}, 32'd0);
    bus.out_ready = 1'b0;
    start(8'h05, 9'd0);
    k = 0;
    while (!bus.out_vld && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("hold out_vld", {31'd0, bus.out_vld}, 32'd1);
    chk("hold out_data", {8'd0, bus.out_data}, 32'h00000A);
    #2 reset_n = 1'b0;
    #1;
    chk("rst out_vld", {31'd0, bus.out_vld}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    run(vecs[0], 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/linked_list_rd_ctrl.md
Name: linked_list_rd_ctrl

Overview:
Read controller that walks a singly linked list held in linked_list_data_mem, starting from a host-supplied head pointer. It drives the memory read port (rd_vld/rd_addr) and consumes rd_data/rd_data_out_vld. Each node's payload goes out on a valid/ready stream, with the last node flagged. Sits between the traversal requester and the data memory, opposite the write controller.

Parameters:
WR_ADDR_WD, 8, node address width; also the width of the next-pointer field.
PAYLOAD_WD, 24, payload field width.
WR_DATA_WD, WR_ADDR_WD+PAYLOAD_WD (32), memory word width; node = {next_ptr[WR_DATA_WD-1:PAYLOAD_WD], payload[PAYLOAD_WD-1:0]}.
MAX_LEN_WD, 9, width of the traversal length limit and the node counter.
TIMEOUT_CYC, 16, memory response watchdog limit (used only with the optional feature).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
trav_start  in  1  one-cycle pulse; accepted only when busy=0
trav_head  in  WR_ADDR_WD  first node address; NULL_PTR means an empty list
trav_max_len  in  MAX_LEN_WD  maximum nodes to visit; 0 is treated as 2^MAX_LEN_WD-1
rd_vld  out  1  memory read request (one cycle per node)
rd_addr  out  WR_ADDR_WD  memory read address
rd_data  in  WR_DATA_WD  memory read data
rd_data_out_vld  in  1  memory read data valid, one cycle after rd_vld
out_vld  out  1  payload valid
out_ready  in  1  consumer ready
out_data  out  PAYLOAD_WD  node payload
out_last  out  1  marks the final node (next_ptr==NULL_PTR)
busy  out  1  traversal in progress
done  out  1  one-cycle pulse at traversal end
err  out  1  one-cycle pulse coincident with done on abnormal end
node_cnt  out  MAX_LEN_WD  nodes emitted in the current/last traversal

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; all outputs 0; rd_addr=0; node_cnt=0. A reset mid-traversal aborts with no done pulse.
- NULL_PTR = all ones of WR_ADDR_WD (package constant).
- FSM:
  - IDLE: trav_start with trav_head==NULL_PTR -> DONE, node_cnt=0, no memory access. trav_start otherwise -> ISSUE, latch cur_ptr=trav_head, latch the length limit, node_cnt=0.
  - ISSUE: rd_vld=1 and rd_addr=cur_ptr for exactly one cycle -> WAIT.
  - WAIT: on rd_data_out_vld, capture payload into out_data and next_ptr into cur_ptr; out_last=(next_ptr==NULL_PTR) | (node_cnt+1==limit); err_pend=(next_ptr!=NULL_PTR)&(node_cnt+1==limit) -> OUT.
  - OUT: out_vld=1 and out_data/out_last held stable until out_ready. On the handshake, node_cnt++; then if out_last -> DONE, else -> ISSUE.
  - DONE: done=1 and err=err_pend for one cycle; busy=0 from the next cycle -> IDLE.
- busy=1 in all states except IDLE. trav_start while busy is ignored.
- Throughput: 3 cycles per node minimum (ISSUE, WAIT, OUT with out_ready=1). Memory latency is fixed at 1 cycle.
- rd_data_out_vld outside WAIT is ignored.
- Self-loop or cyclic list: terminated by the length limit with err=1. The node at the limit is emitted with out_last=1.
- node_cnt saturates at the limit and holds its final value until the next trav_start.

Optional Feature:
LL_RD_TIMEOUT_EN: adds a WAIT-state watchdog counter. If rd_data_out_vld is absent for TIMEOUT_CYC cycles -> DONE with err=1, and no out_vld for that node. Without the macro, WAIT waits indefinitely and there is no counter logic.

Decomposition:
- Package linked_list_pkg holds:
  - WR_ADDR_WD, WR_DATA_WD, DATA_DEPTH, PAYLOAD_WD, NULL_PTR;
  - packed struct ll_node_t {next_ptr, payload};
  - enum ll_rd_state_e {IDLE, ISSUE, WAIT, OUT, DONE}.
- One sub-module: linked_list_rd_out_stage, the single-entry output holding register with valid/ready hold semantics.

Test Plan:
- Nodes at addr 5->9->2 (payloads 0xA, 0xB, 0xC, node 2 next=0xFF), head=5, out_ready=1 -> rd_addr sequence 5,9,2; out_data A,B,C; out_last only on C; done=1, err=0, node_cnt=3.
- head=0xFF -> done pulse one cycle after start, no rd_vld, node_cnt=0, err=0.
- Self-loop at addr 3, trav_max_len=4 -> 4 outputs of payload@3, last has out_last=1, done with err=1, node_cnt=4.
- Same 3-node list, out_ready low 5 cycles on node 2 -> out_vld held, out_data stable, no new rd_vld until the handshake, totals unchanged.
- trav_start during busy, and reset_n low mid-WAIT -> start ignored; reset clears busy/out_vld immediately, no done pulse.
- With LL_RD_TIMEOUT_EN, memory response suppressed -> err+done exactly TIMEOUT_CYC cycles after entering WAIT.
